// File: rtl/sim_dump_trigger.sv
// sim_dump_trigger: dump-window controller for simulation benches and capture logic.
// Counts frames on vs falling edges and tracks the ROM-download flag. It then opens
// one or more dump windows. Each window has a programmable start condition, length,
// gap and repeat count.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   vs, dwnld                 vertical sync and download flag (clk-synchronous)
//   arm                       level enable; rising edge latches config, low aborts
//   mode                      0 IMMEDIATE, 1 LOAD, 2 FRAME, 3 LOAD_FRAME
//   start_frame               frame number that opens the first window
//   win_len, win_gap          frames per window (0 = unlimited), frames between windows
//   win_num                   number of windows (0 treated as 1)
//   frame_cnt                 frame counter
//   dump_en, dump_on, dump_off window level, open pulse, close pulse
//   win_idx, done             current/last window index, all windows completed
module sim_dump_trigger #(
  parameter int unsigned FW = 32,
  parameter int unsigned LW = 16,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vs,
  input  logic          dwnld,
  input  logic          arm,
  input  logic [1:0]    mode,
  input  logic [FW-1:0] start_frame,
  input  logic [LW-1:0] win_len,
  input  logic [LW-1:0] win_gap,
  input  logic [CW-1:0] win_num,
  output logic [FW-1:0] frame_cnt,
  output logic          dump_en,
  output logic          dump_on,
  output logic          dump_off,
  output logic [CW-1:0] win_idx,
  output logic          done
);

  localparam int unsigned CW1 = CW + 1;

  localparam logic [1:0] M_IMM   = 2'd0;
  localparam logic [1:0] M_LOAD  = 2'd1;
  localparam logic [1:0] M_FRAME = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DL, S_WAIT_START, S_ACTIVE, S_GAP, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic          vs_q, dl_q, arm_q;
  logic [FW-1:0] frame_q, frame_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [1:0]    mode_q, mode_d;
  logic [FW-1:0] start_q, start_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] gap_q, gap_d;
  logic [CW-1:0] num_q, num_d;
  logic          dump_en_q, dump_en_d;
  logic          dump_on_q, dump_on_d;
  logic          dump_off_q, dump_off_d;
  logic          done_q, done_d;

  logic          vs_fall, dl_fall, dl_rise, arm_rise, frame_ev, redl, last_win;
  logic [CW-1:0] num_eff;

  // Edge detection; a vs edge coinciding with a download end is discarded
  always_comb begin
    vs_fall  = vs_q & ~vs;
    dl_fall  = dl_q & ~dwnld;
    dl_rise  = ~dl_q & dwnld;
    arm_rise = arm & ~arm_q;
    frame_ev = vs_fall & ~dl_fall;
    redl     = mode_q[0];  // LOAD and LOAD_FRAME restart on a new download
    num_eff  = (num_q == '0) ? CW'(1) : num_q;
    last_win = ({1'b0, idx_q} + CW1'(1)) >= {1'b0, num_eff};
  end

  // Frame counter, window FSM and registered output terms
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    start_d = start_q;
    len_d   = len_q;
    gap_d   = gap_q;
    num_d   = num_q;

    if (dl_fall)      frame_d = '0;
    else if (vs_fall) frame_d = frame_q + FW'(1);

    if (state_q != S_IDLE && !arm) begin
      state_d = S_IDLE;
    end else if (redl && dl_rise &&
                 (state_q == S_WAIT_START || state_q == S_ACTIVE || state_q == S_GAP)) begin
      state_d = S_WAIT_DL;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm_rise) begin
            mode_d  = mode;
            start_d = start_frame;
            len_d   = win_len;
            gap_d   = win_gap;
            num_d   = win_num;
            idx_d   = '0;
            case (mode)
              M_IMM: begin
                state_d = S_ACTIVE;
                cnt_d   = win_len;
              end
              M_FRAME: state_d = S_WAIT_START;
              default: state_d = S_WAIT_DL;
            endcase
          end
        end
        S_WAIT_DL: begin
          if (dl_fall) begin
            if (mode_q == M_LOAD) begin
              state_d = S_ACTIVE;
              cnt_d   = len_q;
            end else begin
              state_d = S_WAIT_START;
            end
          end
        end
        S_WAIT_START: begin
          if (frame_ev && frame_q == start_q) begin
            state_d = S_ACTIVE;
            cnt_d   = len_q;
          end
        end
        S_ACTIVE: begin
          // len 0 keeps the window open until abort or re-download
          if (frame_ev && len_q != '0) begin
            if (cnt_q == LW'(1)) begin
              if (last_win) begin
                state_d = S_DONE;
              end else begin
                state_d = S_GAP;
                cnt_d   = gap_q;
              end
            end else begin
              cnt_d = cnt_q - LW'(1);
            end
          end
        end
        S_GAP: begin
          if (gap_q == '0 || (frame_ev && cnt_q == LW'(1))) begin
            state_d = S_ACTIVE;
            cnt_d   = len_q;
            idx_d   = idx_q + CW'(1);
          end else if (frame_ev) begin
            cnt_d = cnt_q - LW'(1);
          end
        end
        S_DONE:  ;
        default: state_d = S_IDLE;
      endcase
    end

    dump_en_d  = (state_d == S_ACTIVE);
    dump_on_d  = (state_d == S_ACTIVE) && (state_q != S_ACTIVE);
    dump_off_d = (state_q == S_ACTIVE) && (state_d != S_ACTIVE);
    done_d     = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vs_q       <= 1'b0;
      dl_q       <= 1'b0;
      arm_q      <= 1'b0;
      frame_q    <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      mode_q     <= '0;
      start_q    <= '0;
      len_q      <= '0;
      gap_q      <= '0;
      num_q      <= '0;
      dump_en_q  <= 1'b0;
      dump_on_q  <= 1'b0;
      dump_off_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_q       <= vs;
      dl_q       <= dwnld;
      arm_q      <= arm;
      frame_q    <= frame_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      start_q    <= start_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      num_q      <= num_d;
      dump_en_q  <= dump_en_d;
      dump_on_q  <= dump_on_d;
      dump_off_q <= dump_off_d;
      done_q     <= done_d;
    end
  end

  assign frame_cnt = frame_q;
  assign dump_en   = dump_en_q;
  assign dump_on   = dump_on_q;
  assign dump_off  = dump_off_q;
  assign win_idx   = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sim_dump_trigger.sv
// Bench for sim_dump_trigger (FW=4 so wrap-around is reachable). It uses directed
// scenarios followed by random traffic. A frame/window reference model predicts every
// output on every cycle.
module tb_sim_dump_trigger;

  localparam int unsigned FW = 4;
  localparam int unsigned LW = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst, vs, dwnld, arm;
  logic [1:0]    mode;
  logic [FW-1:0] start_frame;
  logic [LW-1:0] win_len, win_gap;
  logic [CW-1:0] win_num;
  logic [FW-1:0] frame_cnt;
  logic          dump_en, dump_on, dump_off, done;
  logic [CW-1:0] win_idx;

  sim_dump_trigger #(.FW(FW), .LW(LW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .vs(vs), .dwnld(dwnld), .arm(arm), .mode(mode),
    .start_frame(start_frame), .win_len(win_len), .win_gap(win_gap), .win_num(win_num),
    .frame_cnt(frame_cnt), .dump_en(dump_en), .dump_on(dump_on), .dump_off(dump_off),
    .win_idx(win_idx), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_on, n_off;
  int on_idx[$];

  // Reference model: window phases as named integers, counts as plain ints
  localparam int P_IDLE = 0, P_WDL = 1, P_WFR = 2, P_OPEN = 3, P_GAP = 4, P_DONE = 5;
  int m_ph, m_frame, m_left, m_idx;
  int c_mode, c_start, c_len, c_gap, c_num;
  bit m_vs_p, m_dl_p, m_arm_p;
  bit e_en, e_on, e_off, e_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic open_win();
    m_ph   = P_OPEN;
    m_left = c_len;
  endtask

  task automatic model_edge();
    bit vf, df, dr, ar, fev, was_open, redl;
    int pre;
    if (rst) begin
      m_ph = P_IDLE; m_frame = 0; m_left = 0; m_idx = 0;
      c_mode = 0; c_start = 0; c_len = 0; c_gap = 0; c_num = 0;
      m_vs_p = 0; m_dl_p = 0; m_arm_p = 0;
      e_en = 0; e_on = 0; e_off = 0; e_done = 0;
      return;
    end
    vf  = m_vs_p && !vs;
    df  = m_dl_p && !dwnld;
    dr  = !m_dl_p && dwnld;
    ar  = arm && !m_arm_p;
    fev = vf && !df;
    pre = m_frame;
    if (df)      m_frame = 0;
    else if (vf) m_frame = (m_frame + 1) % (1 << FW);
    was_open = (m_ph == P_OPEN);
    redl = (c_mode == 1 || c_mode == 3);
    if (m_ph != P_IDLE && !arm) begin
      m_ph = P_IDLE;
    end else if (redl && dr && (m_ph == P_WFR || m_ph == P_OPEN || m_ph == P_GAP)) begin
      m_ph  = P_WDL;
      m_idx = 0;
    end else begin
      case (m_ph)
        P_IDLE: if (ar) begin
          c_mode = int'(mode); c_start = int'(start_frame); c_len = int'(win_len);
          c_gap = int'(win_gap); c_num = int'(win_num); m_idx = 0;
          if (c_mode == 0)      open_win();
          else if (c_mode == 2) m_ph = P_WFR;
          else                  m_ph = P_WDL;
        end
        P_WDL: if (df) begin
          if (c_mode == 1) open_win();
          else             m_ph = P_WFR;
        end
        P_WFR: if (fev && pre == c_start) open_win();
        P_OPEN: if (fev && c_len != 0) begin
          m_left--;
          if (m_left == 0) begin
            if (m_idx + 1 < ((c_num == 0) ? 1 : c_num)) begin
              m_ph = P_GAP; m_left = c_gap;
            end else begin
              m_ph = P_DONE;
            end
          end
        end
        P_GAP: begin
          if (c_gap == 0) begin
            m_idx++; open_win();
          end else if (fev) begin
            m_left--;
            if (m_left == 0) begin m_idx++; open_win(); end
          end
        end
        default: ;
      endcase
    end
    e_en   = (m_ph == P_OPEN);
    e_on   = !was_open && e_en;
    e_off  = was_open && !e_en;
    e_done = (m_ph == P_DONE);
    m_vs_p = vs; m_dl_p = dwnld; m_arm_p = arm;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("frame_cnt", 32'(frame_cnt), 32'(m_frame));
    check("dump_en",   32'(dump_en),   32'(e_en));
    check("dump_on",   32'(dump_on),   32'(e_on));
    check("dump_off",  32'(dump_off),  32'(e_off));
    check("win_idx",   32'(win_idx),   32'(m_idx));
    check("done",      32'(done),      32'(e_done));
    if (dump_on)  begin n_on++; on_idx.push_back(int'(win_idx)); end
    if (dump_off) n_off++;
  endtask

  task automatic cyc(input int n);
    repeat (n) step();
  endtask

  task automatic vs_pulse();
    vs = 1'b1; cyc(2);
    vs = 1'b0; cyc(2);
  endtask

  task automatic dl_pulse();
    dwnld = 1'b1; cyc(2);
    dwnld = 1'b0; cyc(2);
  endtask

  task automatic set_cfg(input int md, input int sf, input int ln, input int gp, input int nm);
    mode = 2'(md); start_frame = FW'(sf); win_len = LW'(ln); win_gap = LW'(gp); win_num = CW'(nm);
  endtask

  initial begin
    rst = 1'b1; vs = 1'b0; dwnld = 1'b0; arm = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    cyc(3);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_dump_en",   32'(dump_en),   32'd0);
    check("rst_done",      32'(done),      32'd0);
    rst = 1'b0;
    cyc(1);

    // Immediate single window of 3 frames
    set_cfg(0, 0, 3, 0, 1);
    n_on = 0; n_off = 0;
    arm = 1'b1; step();
    check("imm_on_next_cycle", 32'(dump_on), 32'd1);
    vs_pulse(); vs_pulse();
    check("imm_open_after_2", 32'(dump_en), 32'd1);
    vs_pulse();
    check("imm_off_count", 32'(n_off), 32'd1);
    check("imm_done", 32'(done), 32'd1);
    check("imm_frame", 32'(frame_cnt), 32'd3);
    arm = 1'b0; step();
    check("imm_done_clears", 32'(done), 32'd0);

    // Frame-triggered window starting at frame 5
    dl_pulse();
    check("frame_clear", 32'(frame_cnt), 32'd0);
    set_cfg(2, 5, 2, 0, 1);
    arm = 1'b1; cyc(1);
    n_on = 0; n_off = 0;
    repeat (5) vs_pulse();
    check("frm_not_yet", 32'(dump_en), 32'd0);
    vs_pulse();
    check("frm_opened", 32'(n_on), 32'd1);
    check("frm_frame6", 32'(frame_cnt), 32'd6);
    vs_pulse(); vs_pulse();
    check("frm_closed", 32'(n_off), 32'd1);
    check("frm_frame8", 32'(frame_cnt), 32'd8);
    check("frm_done", 32'(done), 32'd1);
    arm = 1'b0; cyc(1);

    // Load then frame; vs fall coinciding with download end is not counted
    set_cfg(3, 2, 1, 0, 1);
    arm = 1'b1; cyc(1);
    vs_pulse(); vs_pulse();
    check("lf_frame10", 32'(frame_cnt), 32'd10);
    dwnld = 1'b1; vs = 1'b1; cyc(2);
    dwnld = 1'b0; vs = 1'b0; cyc(1);
    check("lf_coincident_cleared", 32'(frame_cnt), 32'd0);
    cyc(1);
    vs_pulse(); vs_pulse();
    check("lf_wait", 32'(dump_en), 32'd0);
    vs_pulse();
    check("lf_open", 32'(dump_en), 32'd1);
    check("lf_frame3", 32'(frame_cnt), 32'd3);
    vs_pulse();
    check("lf_done", 32'(done), 32'd1);
    arm = 1'b0; cyc(1);

    // Three windows of 2 frames with a 1-frame gap
    set_cfg(0, 0, 2, 1, 3);
    n_on = 0; n_off = 0; on_idx.delete();
    arm = 1'b1; cyc(1);
    repeat (8) vs_pulse();
    check("multi_on", 32'(n_on), 32'd3);
    check("multi_off", 32'(n_off), 32'd3);
    check("multi_done", 32'(done), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i < on_idx.size()) check("multi_idx_seq", 32'(on_idx[i]), 32'(i));
    end
    arm = 1'b0; step();
    check("idx_holds_after_abort", 32'(win_idx), 32'd2);

    // Abort an unlimited window
    set_cfg(0, 0, 0, 0, 1);
    arm = 1'b1; cyc(1);
    check("abort_idx_cleared", 32'(win_idx), 32'd0);
    repeat (3) vs_pulse();
    check("abort_still_open", 32'(dump_en), 32'd1);
    arm = 1'b0; step();
    check("abort_off_pulse", 32'(dump_off), 32'd1);
    check("abort_en_low", 32'(dump_en), 32'd0);
    step();
    check("abort_off_single", 32'(dump_off), 32'd0);

    // Re-download during the second window of a LOAD session
    set_cfg(1, 0, 2, 0, 3);
    arm = 1'b1; cyc(1);
    dl_pulse();
    check("rdl_open", 32'(dump_en), 32'd1);
    vs_pulse(); vs_pulse();
    check("rdl_idx1", 32'(win_idx), 32'd1);
    check("rdl_open2", 32'(dump_en), 32'd1);
    dwnld = 1'b1; step();
    check("rdl_off_pulse", 32'(dump_off), 32'd1);
    check("rdl_idx0", 32'(win_idx), 32'd0);
    dwnld = 1'b0; step();
    check("rdl_reopen", 32'(dump_on), 32'd1);
    arm = 1'b0; cyc(1);

    // Wrap-around: 15 -> 0, start_frame 0 matches after wrap
    dl_pulse();
    repeat (15) vs_pulse();
    check("wrap_frame15", 32'(frame_cnt), 32'd15);
    set_cfg(2, 0, 2, 0, 1);
    arm = 1'b1; cyc(1);
    vs_pulse();
    check("wrap_frame0", 32'(frame_cnt), 32'd0);
    check("wrap_not_open", 32'(dump_en), 32'd0);
    vs_pulse();
    check("wrap_open", 32'(dump_en), 32'd1);
    arm = 1'b0; cyc(1);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) vs = ~vs;
      if ($urandom_range(0, 39) == 0) dwnld = ~dwnld;
      if ($urandom_range(0, 7) == 0)
        set_cfg($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 3),
                $urandom_range(0, 2), $urandom_range(0, 3));
      if (arm) begin
        if ($urandom_range(0, 79) == 0) arm = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        arm = 1'b1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
